// File: rtl/calc_pkg.sv
// Shared calculator constants: operand width, result-channel indices,
// per-channel slot state and a select-to-one-hot helper.
package calc_pkg;

  localparam int CALC_WIDTH = 8;
  localparam int NUM_CH     = 4;

  localparam logic [1:0] CH_ADD = 2'd0;
  localparam logic [1:0] CH_SUB = 2'd1;
  localparam logic [1:0] CH_MUL = 2'd2;
  localparam logic [1:0] CH_CMP = 2'd3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] ch_decode(input logic [1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_1_4_reg_if.sv
// Handshake bus of the 1:4 result demux: one upstream producer port and
// four registered consumer channels with per-channel delivery counters.
interface demux_1_4_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] din;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

  // Environment side: producer plus the four consumers.
  modport master (
    output din, sel, in_valid, out_ready,
    input  in_ready, y0, y1, y2, y3, out_valid, cnt0, cnt1, cnt2, cnt3
  );

  // Demux side.
  modport slave (
    input  din, sel, in_valid, out_ready,
    output in_ready, y0, y1, y2, y3, out_valid, cnt0, cnt1, cnt2, cnt3
  );
endinterface

// File: rtl/demux_chan_slot.sv
// One output channel of the demux: single-entry holding register, its
// EMPTY/FULL state and a wrapping count of words handed to the consumer.
module demux_chan_slot
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);

  slot_state_e      r_state;
  slot_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  // A drain only counts when the slot actually holds a word.
  assign w_drain = drain && (r_state == SLOT_FULL);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SLOT_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state: load wins over drain, so drain+load keeps the slot full.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (load)              w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (w_drain && !load)  w_state_nxt = SLOT_EMPTY;
      default:                           w_state_nxt = SLOT_EMPTY;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    valid = (r_state == SLOT_FULL);
  end

  // Data register; keeps its last word while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (load) r_q <= d;
  end

  // Delivered-word counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (w_drain) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign q   = r_q;
  assign cnt = r_cnt;

endmodule

// File: rtl/demux_1_4_reg.sv
// Registered 1:4 result demux. Steers din to the slot picked by sel; each
// slot handshakes with its own consumer so one stalled sink blocks only
// traffic addressed to it.
module demux_1_4_reg
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_1_4_reg_if.slave bus
);

  logic                          w_accept;
  logic [NUM_CH-1:0]             w_load;
  logic [NUM_CH-1:0]             w_drain;
  logic [NUM_CH-1:0]             w_valid;
  logic [NUM_CH-1:0][WIDTH-1:0]  w_q;
  logic [NUM_CH-1:0][CNT_W-1:0]  w_cnt;

  // Ready looks only at the addressed slot; a draining full slot still
  // accepts, so back-to-back traffic runs without bubbles.
  assign bus.in_ready = !w_valid[bus.sel] || bus.out_ready[bus.sel];
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_load       = w_accept ? ch_decode(bus.sel) : '0;
  assign w_drain      = w_valid & bus.out_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_chan_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_load[g]),
      .drain (w_drain[g]),
      .d     (bus.din),
      .q     (w_q[g]),
      .valid (w_valid[g]),
      .cnt   (w_cnt[g])
    );
  end

  assign bus.out_valid = w_valid;
  assign bus.y0   = w_q[CH_ADD];
  assign bus.y1   = w_q[CH_SUB];
  assign bus.y2   = w_q[CH_MUL];
  assign bus.y3   = w_q[CH_CMP];
  assign bus.cnt0 = w_cnt[CH_ADD];
  assign bus.cnt1 = w_cnt[CH_SUB];
  assign bus.cnt2 = w_cnt[CH_MUL];
  assign bus.cnt3 = w_cnt[CH_CMP];

endmodule

// File: tb/tb_demux_1_4_reg.sv
// Directed bench for demux_1_4_reg: table of single-cycle vectors plus
// hand-written sequences for async reset and counter wrap.
module tb_demux_1_4_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux_1_4_reg_if #(.WIDTH(8), .CNT_W(8)) bus ();

  demux_1_4_reg #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    logic [1:0]  sel;
    logic        vin;
    logic [3:0]  ordy;
    logic        exp_rdy;   // in_ready before the edge
    logic [3:0]  exp_vld;   // out_valid after the edge
    logic [31:0] exp_y;     // {y3,y2,y1,y0} after the edge
    logic [31:0] exp_cnt;   // {cnt3,cnt2,cnt1,cnt0} after the edge
  } vec_t;

  vec_t tbl [11];

  function automatic logic [31:0] cur_y();
    return {bus.y3, bus.y2, bus.y1, bus.y0};
  endfunction

  function automatic logic [31:0] cur_cnt();
    return {bus.cnt3, bus.cnt2, bus.cnt1, bus.cnt0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] din, input logic [1:0] sel,
                       input logic vin, input logic [3:0] ordy);
    bus.din       = din;
    bus.sel       = sel;
    bus.in_valid  = vin;
    bus.out_ready = ordy;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    tbl[0]  = '{8'hA5, 2'd2, 1'b1, 4'hF, 1'b1, 4'b0100, 32'h00A5_0000, 32'h0000_0000};
    tbl[1]  = '{8'h00, 2'd0, 1'b0, 4'hF, 1'b1, 4'b0000, 32'h00A5_0000, 32'h0001_0000};
    tbl[2]  = '{8'h11, 2'd1, 1'b1, 4'h0, 1'b1, 4'b0010, 32'h00A5_1100, 32'h0001_0000};
    tbl[3]  = '{8'h22, 2'd1, 1'b1, 4'h0, 1'b0, 4'b0010, 32'h00A5_1100, 32'h0001_0000};
    tbl[4]  = '{8'h22, 2'd1, 1'b1, 4'h2, 1'b1, 4'b0010, 32'h00A5_2200, 32'h0001_0100};
    tbl[5]  = '{8'h00, 2'd1, 1'b0, 4'h2, 1'b1, 4'b0000, 32'h00A5_2200, 32'h0001_0200};
    tbl[6]  = '{8'h33, 2'd0, 1'b1, 4'h0, 1'b1, 4'b0001, 32'h00A5_2233, 32'h0001_0200};
    tbl[7]  = '{8'h44, 2'd0, 1'b1, 4'h0, 1'b0, 4'b0001, 32'h00A5_2233, 32'h0001_0200};
    tbl[8]  = '{8'h7F, 2'd3, 1'b1, 4'h0, 1'b1, 4'b1001, 32'h7FA5_2233, 32'h0001_0200};
    tbl[9]  = '{8'h99, 2'd2, 1'b0, 4'h0, 1'b1, 4'b1001, 32'h7FA5_2233, 32'h0001_0200};
    tbl[10] = '{8'h00, 2'd0, 1'b0, 4'h9, 1'b1, 4'b0000, 32'h7FA5_2233, 32'h0101_0201};

    // Reset held for three cycles under random inputs.
    rst_n = 1'b0;
    drive(8'h00, 2'd0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(8'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));
    end
    #1;
    chk("rst_y",   cur_y(), 32'h0);
    chk("rst_vld", {28'h0, bus.out_valid}, 32'h0);
    chk("rst_cnt", cur_cnt(), 32'h0);
    chk("rst_rdy", {31'h0, bus.in_ready}, 32'h1);
    @(negedge clk);
    drive(8'h00, 2'd0, 1'b0, 4'h0);
    rst_n = 1'b1;

    // Table: routing, backpressure, no-bubble refill, independence, dual drain.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(tbl[i].din, tbl[i].sel, tbl[i].vin, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d_rdy", i), {31'h0, bus.in_ready}, {31'h0, tbl[i].exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_vld", i), {28'h0, bus.out_valid}, {28'h0, tbl[i].exp_vld});
      chk($sformatf("v%0d_y", i),   cur_y(),   tbl[i].exp_y);
      chk($sformatf("v%0d_cnt", i), cur_cnt(), tbl[i].exp_cnt);
    end

    // Fill all four slots with consumers stalled.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(8'h10 + 8'(k), 2'(k), 1'b1, 4'h0);
    end
    @(negedge clk);
    drive(8'h00, 2'd0, 1'b0, 4'h0);
    chk("full_vld", {28'h0, bus.out_valid}, 32'hF);
    chk("full_y",   cur_y(), 32'h1312_1110);

    // Async reset pulse between edges: clears before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", {28'h0, bus.out_valid}, 32'h0);
    chk("arst_cnt", cur_cnt(), 32'h0);
    chk("arst_y",   cur_y(), 32'h0);
    chk("arst_rdy", {31'h0, bus.in_ready}, 32'h1);
    #1 rst_n = 1'b1;

    // Normal accept after release.
    @(negedge clk);
    drive(8'h5A, 2'd1, 1'b1, 4'h0);
    #1 chk("post_rdy", {31'h0, bus.in_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("post_vld", {28'h0, bus.out_valid}, 32'h2);
    chk("post_y1",  {24'h0, bus.y1}, 32'h5A);

    // 256 words back-to-back on ch0 with ch1 left stalled.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      drive(8'(i), 2'd0, 1'b1, 4'h1);
      #1 chk($sformatf("wrap_rdy%0d", i), {31'h0, bus.in_ready}, 32'h1);
    end
    @(negedge clk);
    drive(8'h00, 2'd0, 1'b0, 4'h1);
    chk("wrap_y0",   {24'h0, bus.y0}, 32'hFF);
    chk("wrap_c255", {24'h0, bus.cnt0}, 32'hFF);
    @(posedge clk);
    #1;
    chk("wrap_c0",   {24'h0, bus.cnt0}, 32'h0);
    chk("wrap_vld",  {28'h0, bus.out_valid}, 32'h2);
    chk("wrap_y1",   {24'h0, bus.y1}, 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
